// File: rtl/adc_lane_deskew.sv
// adc_lane_deskew: per-lane IODELAY tap sweep and eye-centre calibration for an
// LVDS ADC capture path. Sweeps all taps against a known test pattern, tracks
// the widest passing window per lane, then loads each lane's window centre.
module adc_lane_deskew #(
    parameter int unsigned LANES    = 8,
    parameter int unsigned TAP_W    = 5,
    parameter int unsigned SETTLE   = 16,
    parameter int unsigned CHECK    = 64,
    parameter int unsigned MIN_WIN  = 4,
    parameter int unsigned FAIL_TAP = 0
) (
    input  logic                     adc_dco_clk,
    input  logic                     adc_reset_n,
    input  logic                     start,
    input  logic [LANES-1:0]         pattern_rise,
    input  logic [LANES-1:0]         pattern_fall,
    input  logic [LANES-1:0]         adc_data_p_s,
    input  logic [LANES-1:0]         adc_data_n_s,
    output logic                     delay_ld,
    output logic [LANES*TAP_W-1:0]   delay_wdata,
    output logic                     busy,
    output logic                     done,
    output logic [LANES-1:0]         lane_lock,
    output logic [LANES-1:0]         data_rise,
    output logic [LANES-1:0]         data_fall,
    output logic                     data_valid
);

    // Run lengths need one extra bit: every tap may pass.
    localparam int unsigned LEN_W   = TAP_W + 1;
    localparam int unsigned CNT_MAX = (SETTLE > CHECK) ? SETTLE : CHECK;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_W-1:0] TAP_LAST    = {TAP_W{1'b1}};
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK - 1);
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_WIN);
    localparam logic [TAP_W-1:0] FAIL_VAL    = TAP_W'(FAIL_TAP);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StCheck,
        StNext,
        StApply,
        StDone
    } state_t;

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   tap_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LANES-1:0]   pat_r_q, pat_f_q;
    logic [LANES-1:0]   pass_q;
    logic [LANES-1:0]   mismatch;

    logic [LEN_W-1:0]   run_len_q    [LANES];
    logic [TAP_W-1:0]   run_start_q  [LANES];
    logic [LEN_W-1:0]   best_len_q   [LANES];
    logic [TAP_W-1:0]   best_start_q [LANES];
    logic [LEN_W-1:0]   run_len_d    [LANES];
    logic [TAP_W-1:0]   run_start_d  [LANES];
    logic [LEN_W-1:0]   best_len_d   [LANES];
    logic [TAP_W-1:0]   best_start_d [LANES];
    logic [LEN_W-1:0]   half_len     [LANES];
    logic [TAP_W-1:0]   apply_tap    [LANES];
    logic [LANES-1:0]   lock_now;

    assign mismatch   = (adc_data_p_s ^ pat_r_q) | (adc_data_n_s ^ pat_f_q);
    assign data_valid = done;

    // State register
    always_ff @(posedge adc_dco_clk) begin
        if (!adc_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StLoad;
            StLoad:         state_d = StSettle;
            StSettle:       if (cnt_q == SETTLE_LAST) state_d = StCheck;
            StCheck:        if (cnt_q == CHECK_LAST) state_d = StNext;
            StNext:         state_d = (tap_q == TAP_LAST) ? StApply : StLoad;
            StApply:        state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Per-lane window tracker update and eye-centre selection
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            run_len_d[i]    = run_len_q[i];
            run_start_d[i]  = run_start_q[i];
            best_len_d[i]   = best_len_q[i];
            best_start_d[i] = best_start_q[i];
            if (pass_q[i]) begin
                if (run_len_q[i] == '0) run_start_d[i] = tap_q;
                run_len_d[i] = run_len_q[i] + 1'b1;
                // Strictly greater keeps the lowest-tap window on ties.
                if (run_len_d[i] > best_len_q[i]) begin
                    best_len_d[i]   = run_len_d[i];
                    best_start_d[i] = run_start_d[i];
                end
            end else begin
                run_len_d[i] = '0;
            end
            half_len[i]  = (best_len_q[i] - 1'b1) >> 1;
            lock_now[i]  = (best_len_q[i] >= MIN_LEN);
            apply_tap[i] = lock_now[i] ? (best_start_q[i] + half_len[i][TAP_W-1:0]) : FAIL_VAL;
        end
    end

    // Datapath: sweep counters, trackers, registered outputs
    always_ff @(posedge adc_dco_clk) begin
        if (!adc_reset_n) begin
            tap_q       <= '0;
            cnt_q       <= '0;
            pat_r_q     <= '0;
            pat_f_q     <= '0;
            pass_q      <= '0;
            delay_ld    <= 1'b0;
            delay_wdata <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lane_lock   <= '0;
            data_rise   <= '0;
            data_fall   <= '0;
            for (int i = 0; i < LANES; i++) begin
                run_len_q[i]    <= '0;
                run_start_q[i]  <= '0;
                best_len_q[i]   <= '0;
                best_start_q[i] <= '0;
            end
        end else begin
            data_rise <= adc_data_p_s;
            data_fall <= adc_data_n_s;
            cnt_q     <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            delay_ld  <= (state_q == StLoad) || (state_q == StApply);
            busy      <= (state_q != StIdle) && (state_q != StDone);
            done      <= (state_q == StDone);
            if (state_q == StDone) lane_lock <= lock_now;

            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        pat_r_q <= pattern_rise;
                        pat_f_q <= pattern_fall;
                        tap_q   <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            run_len_q[i]    <= '0;
                            run_start_q[i]  <= '0;
                            best_len_q[i]   <= '0;
                            best_start_q[i] <= '0;
                        end
                    end
                end
                StLoad: begin
                    pass_q <= '1;
                    for (int i = 0; i < LANES; i++) begin
                        delay_wdata[i*TAP_W +: TAP_W] <= tap_q;
                    end
                end
                StSettle: begin
                end
                StCheck: begin
                    pass_q <= pass_q & ~mismatch;
                end
                StNext: begin
                    for (int i = 0; i < LANES; i++) begin
                        run_len_q[i]    <= run_len_d[i];
                        run_start_q[i]  <= run_start_d[i];
                        best_len_q[i]   <= best_len_d[i];
                        best_start_q[i] <= best_start_d[i];
                    end
                    if (tap_q != TAP_LAST) tap_q <= tap_q + 1'b1;
                end
                StApply: begin
                    for (int i = 0; i < LANES; i++) begin
                        delay_wdata[i*TAP_W +: TAP_W] <= apply_tap[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_lane_deskew.sv
// Testbench for adc_lane_deskew: a lane model returns the pattern only for
// passing taps of a per-lane pass map; results are compared against a table
// and against a window-search reference model.
module tb_adc_lane_deskew;

    localparam int L  = 8;
    localparam int TW = 5;
    localparam int NT = 32;
    localparam int MIN_WIN = 4;
    localparam int FAIL_TAP = 0;
    localparam int DONE_EDGE = 2626;

    logic            clk = 1'b0;
    logic            adc_reset_n;
    logic            start;
    logic [L-1:0]    pattern_rise, pattern_fall;
    logic [L-1:0]    adc_p, adc_n;
    logic            delay_ld;
    logic [L*TW-1:0] delay_wdata;
    logic            busy, done, data_valid;
    logic [L-1:0]    lane_lock, data_rise, data_fall;

    int passed = 0;
    int total  = 0;

    // Lane model state
    logic [NT-1:0] pmap     [L];
    logic [TW-1:0] cur_tap  [L];
    logic [1:0]    fail_mode[L];
    logic [L-1:0]  pat_r, pat_f;
    int            since_ld = 100;
    bit            dp_mode  = 1'b0;
    logic [7:0]    dp_cnt   = 8'h01;
    logic [7:0]    last_p   = 8'h00;
    logic [7:0]    last_n   = 8'h00;

    typedef struct {
        string             name;
        logic [L-1:0][NT-1:0] map;
        logic [L-1:0][TW-1:0] tap;
        logic [L-1:0]      lock;
        logic [L-1:0]      pr;
        logic [L-1:0]      pf;
    } vec_t;

    vec_t vecs[3];

    adc_lane_deskew dut (
        .adc_dco_clk  (clk),
        .adc_reset_n  (adc_reset_n),
        .start        (start),
        .pattern_rise (pattern_rise),
        .pattern_fall (pattern_fall),
        .adc_data_p_s (adc_p),
        .adc_data_n_s (adc_n),
        .delay_ld     (delay_ld),
        .delay_wdata  (delay_wdata),
        .busy         (busy),
        .done         (done),
        .lane_lock    (lane_lock),
        .data_rise    (data_rise),
        .data_fall    (data_fall),
        .data_valid   (data_valid)
    );

    always #5 clk = ~clk;

    // Lane model: follow loaded taps; random data while the delay settles,
    // pattern on passing taps, a corrupted rise and/or fall bit otherwise.
    always @(negedge clk) begin
        if (dp_mode) begin
            adc_p  = dp_cnt;
            adc_n  = ~dp_cnt;
            last_p = dp_cnt;
            last_n = ~dp_cnt;
            dp_cnt = dp_cnt + 8'd1;
        end else begin
            if (delay_ld === 1'b1) begin
                for (int i = 0; i < L; i++) begin
                    cur_tap[i]   = delay_wdata[i*TW +: TW];
                    fail_mode[i] = 2'($urandom_range(0, 2));
                end
                since_ld = 0;
            end else if (since_ld < 1000) begin
                since_ld++;
            end
            for (int i = 0; i < L; i++) begin
                if (since_ld < 10) begin
                    adc_p[i] = 1'($urandom);
                    adc_n[i] = 1'($urandom);
                end else if (pmap[i][cur_tap[i]]) begin
                    adc_p[i] = pat_r[i];
                    adc_n[i] = pat_f[i];
                end else begin
                    adc_p[i] = pat_r[i] ^ (fail_mode[i] != 2'd1);
                    adc_n[i] = pat_f[i] ^ (fail_mode[i] != 2'd0);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [NT-1:0] win(input int lo, input int hi);
        logic [NT-1:0] m = '0;
        for (int t = 0; t < NT; t++) if (t >= lo && t <= hi) m[t] = 1'b1;
        return m;
    endfunction

    // Reference: longest run of passing taps, earliest start on ties, centre
    // at start + (len-1)/2; unlocked lanes get FAIL_TAP.
    function automatic logic [TW:0] ref_lane(input logic [NT-1:0] m);
        int bl = 0;
        int bs = 0;
        for (int s = 0; s < NT; s++) begin
            int l = 0;
            while (s + l < NT && m[s+l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        if (bl >= MIN_WIN) return {1'b1, TW'(bs + (bl - 1) / 2)};
        return {1'b0, TW'(FAIL_TAP)};
    endfunction

    function automatic logic [NT-1:0] rand_map();
        int lo, len;
        logic [NT-1:0] m;
        case ($urandom_range(0, 4))
            0: m = $urandom;
            1: m = (4'($urandom_range(0, 1)) != 0) ? '1 : '0;
            2: begin
                lo = $urandom_range(0, 20);
                len = $urandom_range(1, 8);
                m = win(lo, lo + len - 1) | win(lo + len + 1, lo + len + $urandom_range(1, 8));
            end
            default: begin
                lo = $urandom_range(0, 31);
                len = $urandom_range(1, 14);
                m = win(lo, lo + len - 1);
            end
        endcase
        return m;
    endfunction

    // One full calibration with timing, strobe count and final tap checks.
    task automatic do_run(input string nm, input logic [L-1:0][NT-1:0] map,
                          input logic [L-1:0] pr, input logic [L-1:0] pf, input bit noisy,
                          input logic [L-1:0][TW-1:0] etap, input logic [L-1:0] elock);
        int n = 0;
        int n_ld = 0;
        bit overlap = 1'b0;
        for (int i = 0; i < L; i++) pmap[i] = map[i];
        pat_r = pr;
        pat_f = pf;
        pattern_rise = pr;
        pattern_fall = pf;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Patterns must have been captured at start; scramble the inputs.
        pattern_rise = L'($urandom);
        pattern_fall = L'($urandom);
        while (n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (delay_ld) n_ld++;
            if (busy && done) overlap = 1'b1;
            start = noisy && (n % 700 == 0);
            if (done) break;
        end
        start = 1'b0;
        chk({nm, "_done_edge"}, 64'(n), 64'(DONE_EDGE));
        chk({nm, "_ld_count"}, 64'(n_ld), 64'd33);
        chk({nm, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        chk({nm, "_lock"}, 64'(lane_lock), 64'(elock));
        for (int i = 0; i < L; i++)
            chk($sformatf("%s_tap%0d", nm, i), 64'(delay_wdata[i*TW +: TW]), 64'(etap[i]));
    endtask

    task automatic rand_run(input string nm, input bit noisy);
        logic [L-1:0][NT-1:0] m;
        logic [L-1:0][TW-1:0] et;
        logic [L-1:0] el;
        logic [TW:0] r;
        for (int i = 0; i < L; i++) begin
            m[i] = rand_map();
            r = ref_lane(m[i]);
            et[i] = r[TW-1:0];
            el[i] = r[TW];
        end
        do_run(nm, m, L'($urandom), L'($urandom), noisy, et, el);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < L; i++) begin
            pmap[i] = '0;
            cur_tap[i] = '0;
            fail_mode[i] = 2'd2;
        end
        pat_r = '0;
        pat_f = '0;
        adc_reset_n = 1'b0;
        start = 1'b0;
        pattern_rise = '0;
        pattern_fall = '0;

        // Vector table from the directed scenarios
        vecs[0].name = "clean_eye";
        vecs[0].pr = 8'hA5;
        vecs[0].pf = 8'h5A;
        vecs[0].lock = 8'hFF;
        for (int i = 0; i < L; i++) begin
            vecs[0].map[i] = win(10, 19);
            vecs[0].tap[i] = 5'd14;
        end

        vecs[1].name = "skew_dead";
        vecs[1].pr = 8'h3C;
        vecs[1].pf = 8'hC3;
        vecs[1].lock = 8'hDF;
        for (int i = 0; i < L; i++) begin
            vecs[1].map[i] = win(12, 15);
            vecs[1].tap[i] = 5'd13;
        end
        vecs[1].map[0] = win(0, 7);
        vecs[1].tap[0] = 5'd3;
        vecs[1].map[3] = win(24, 31);
        vecs[1].tap[3] = 5'd27;
        vecs[1].map[5] = '0;
        vecs[1].tap[5] = 5'd0;

        vecs[2].name = "tie_short";
        vecs[2].pr = 8'h0F;
        vecs[2].pf = 8'h96;
        vecs[2].lock = 8'h6B;
        vecs[2].map[0] = '1;                            vecs[2].tap[0] = 5'd15;
        vecs[2].map[1] = win(2, 5) | win(20, 23);       vecs[2].tap[1] = 5'd3;
        vecs[2].map[2] = win(8, 10);                    vecs[2].tap[2] = 5'd0;
        vecs[2].map[3] = win(28, 31);                   vecs[2].tap[3] = 5'd29;
        vecs[2].map[4] = win(0, 1) | win(29, 31);       vecs[2].tap[4] = 5'd0;
        vecs[2].map[5] = win(0, 3);                     vecs[2].tap[5] = 5'd1;
        vecs[2].map[6] = win(5, 9) | win(11, 15);       vecs[2].tap[6] = 5'd7;
        vecs[2].map[7] = '0;                            vecs[2].tap[7] = 5'd0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {delay_wdata, lane_lock, data_rise, data_fall, delay_ld, busy, done, data_valid},
            64'd0);
        adc_reset_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (delay_ld || busy || done || data_valid || delay_wdata != '0 || lane_lock != '0)
                cnt++;
        end
        chk("idle_quiet_cycles", 64'(cnt), 64'd0);

        // Directed table
        for (int v = 0; v < 3; v++)
            do_run(vecs[v].name, vecs[v].map, vecs[v].pr, vecs[v].pf, 1'b0,
                   vecs[v].tap, vecs[v].lock);

        // Randomized runs against the reference model
        for (int r = 0; r < 3; r++) rand_run($sformatf("rand%0d", r), 1'b0);

        // Abort mid-calibration, then restart with stray start pulses while busy
        for (int i = 0; i < L; i++) pmap[i] = win(10, 19);
        pat_r = 8'hA5;
        pat_f = 8'h5A;
        pattern_rise = pat_r;
        pattern_fall = pat_f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        adc_reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_reset_outputs", {44'd0, busy, done, delay_ld, lane_lock, delay_wdata[9:0]},
            64'd0);
        @(posedge clk);
        #1;
        adc_reset_n = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (delay_ld || busy || done) cnt++;
        end
        chk("abort_quiet_cycles", 64'(cnt), 64'd0);
        rand_run("restart", 1'b1);

        // Data path after done: 1-cycle latency, valid held
        dp_mode = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("data_rise", 64'(data_rise), 64'(last_p));
            chk("data_fall", 64'(data_fall), 64'(last_n));
            chk("data_valid", 64'(data_valid), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_lane_deskew.md
# adc_lane_deskew

Per-lane input-delay calibration controller for the AD9284 LVDS capture path. It sits in the `adc_dco_clk` domain, between the per-lane IDDR outputs and the IODELAYE1 variable-load ports. It sweeps every delay tap while the ADC drives a known test pattern, finds the widest passing eye per lane, and loads that eye's centre tap. After calibration it presents the aligned rise/fall data words with a valid flag.

## Interface
- `LANES`, 8, number of LVDS data lanes
- `TAP_W`, 5, delay tap width (IODELAYE1 CNTVALUE)
- `SETTLE`, 16, cycles waited after each tap load before comparing (≥1)
- `CHECK`, 64, compare cycles per tap (≥1)
- `MIN_WIN`, 4, minimum passing-window length for a lane to lock
- `FAIL_TAP`, 0, tap loaded into a lane that fails to lock

Ports:
- `adc_dco_clk` in 1: ADC DCO clock (BUFR output), the only clock
- `adc_reset_n` in 1: synchronous, active-low reset
- `start` in 1: calibration request pulse
- `pattern_rise` in LANES: expected Q1 bits; sampled when `start` is accepted
- `pattern_fall` in LANES: expected Q2 bits; sampled when `start` is accepted
- `adc_data_p_s` in LANES: IDDR Q1 per lane
- `adc_data_n_s` in LANES: IDDR Q2 per lane
- `delay_ld` out 1: one-cycle tap-load strobe to all IODELAYs
- `delay_wdata` out LANES*TAP_W: per-lane tap; lane i occupies bits [i*TAP_W +: TAP_W]
- `busy` out 1: calibration in progress
- `done` out 1: calibration finished; held until the next accepted `start`
- `lane_lock` out LANES: lane found a window ≥ MIN_WIN
- `data_rise` out LANES: registered Q1 word
- `data_fall` out LANES: registered Q2 word
- `data_valid` out 1: equals `done`

## Operation
- The state machine has seven states: IDLE, LOAD, SETTLE, CHECK, NEXT, APPLY, DONE.
- IDLE/DONE:
  - `start`=1 latches both patterns, clears the trackers, sets tap=0 and goes to LOAD.
  - `start` is ignored in every other state.
- LOAD: `delay_ld`=1 for one cycle, with every lane's `delay_wdata` set to the current tap. Next state is SETTLE.
- SETTLE: counts SETTLE cycles, then goes to CHECK. Inputs are not compared.
- CHECK: for CHECK cycles, per lane, pass is cleared if `adc_data_p_s[i]`≠`pattern_rise[i]` or `adc_data_n_s[i]`≠`pattern_fall[i]`. Pass is preset to 1 on entry.
- NEXT: one cycle. Per lane:
  - If pass: if run_len==0, set run_start=tap. Then run_len+=1. If the new run_len > best_len (strictly greater), set best_start=run_start and best_len=new run_len.
  - If fail: run_len=0.
  - Then, if tap==2^TAP_W−1, go to APPLY; otherwise tap+=1 and go to LOAD.
- APPLY: one cycle.
  - `delay_ld`=1.
  - Lane tap = best_start + ((best_len−1)>>1) if best_len ≥ MIN_WIN, else FAIL_TAP.
  - `lane_lock[i]` = (best_len ≥ MIN_WIN).
  - Next state is DONE.
- Windows do not wrap: a pass at tap max does not join a pass at tap 0.
- On equal-length windows the lowest-tap window wins.
- Width rules:
  - run_len/best_len are TAP_W+1 bits, since all 2^TAP_W taps may pass.
  - Centre arithmetic is unsigned, truncated to TAP_W bits, and cannot overflow.
- `data_rise`/`data_fall` register the IDDR inputs every cycle in all states. Consumers qualify them with `data_valid`.

## Timing
- Reset (edge with `adc_reset_n`=0):
  - State goes to IDLE.
  - `delay_ld`, `busy`, `done`, `data_valid` = 0.
  - `delay_wdata`, `lane_lock`, `data_rise`, `data_fall` = 0; patterns and trackers = 0.
- Reset asserted mid-calibration aborts immediately. No `delay_ld` is issued, and a new `start` is required.
- `busy`=1 from the cycle after `start` is accepted through APPLY, inclusive. `busy` and `done` are never both 1.
- Per tap: 1 (LOAD) + SETTLE + CHECK + 1 (NEXT) cycles.
- `done` rises 2^TAP_W·(SETTLE+CHECK+2)+2 edges after the edge sampling `start`. With defaults this is 2626.
- APPLY's `delay_ld` is the cycle before `done` rises, and `lane_lock` updates on the same edge as `done`.
- Data latency: `data_rise`/`data_fall` are the inputs delayed by 1 cycle.
- `start` held high continuously causes a restart on every DONE entry (one cycle in DONE).

## Test plan
- Reset/idle:
  - Stimulus: hold `adc_reset_n`=0 for 3 cycles, then release.
  - Required: all outputs 0, no `delay_ld` pulse over 100 cycles.
- Clean eye:
  - Stimulus: lane model matches pattern rise=0xA5/fall=0x5A only for taps 10..19 on all lanes.
  - Required: 33 `delay_ld` pulses; final `delay_wdata` lane taps = 14; `lane_lock`=0xFF; `done` at edge 2626.
- Per-lane skew plus dead lane:
  - Stimulus: lane0 passes taps 0..7, lane3 passes 24..31, lane5 never passes, others pass 12..15.
  - Required: taps lane0=3, lane3=27, lane5=FAIL_TAP(0), others=13; `lane_lock`=0xDF.
- Tie and short window:
  - Stimulus: lane1 passes 2..5 and 20..23; lane2 passes 8..10 only.
  - Required: lane1 tap=3 (first window wins); lane2 unlocked, tap 0.
- Abort and restart:
  - Stimulus: `adc_reset_n`=0 at cycle 500 of calibration, then `start`.
  - Required: no APPLY; new run yields the correct taps; `start` pulses during `busy` are ignored.
- Data path:
  - Stimulus: after `done`, drive incrementing Q1/Q2.
  - Required: `data_rise`/`data_fall` follow with 1-cycle latency; `data_valid`=1.
